// File: rtl/avmm_sdram_reader.sv
// avmm_sdram_reader: Avalon-MM burst read master splitting a start/addr/count request into SDRAM bursts.
module avmm_sdram_reader #(
  parameter int SDRAM_DATA_W = 128,
  parameter int ADDR_W       = 32,
  parameter int BURST_W      = 11,
  parameter int CNT_W        = 32,
  parameter int MAX_BURST    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       read_addr,
  input  logic [CNT_W-1:0]        read_cnt,
  input  logic                    read_start,
  output logic                    read_valid,
  output logic [SDRAM_DATA_W-1:0] read_data,
  output logic                    read_done,
  output logic [ADDR_W-1:0]       address,
  output logic [BURST_W-1:0]      burstcount,
  output logic                    read,
  input  logic                    waitrequest,
  input  logic [SDRAM_DATA_W-1:0] readdata,
  input  logic                    readdatavalid
);
  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0] remaining;
  logic [BURST_W-1:0] beat_cnt, cur_burst, bc;
  logic beat, last_beat;
  assign bc = (remaining > CNT_W'(MAX_BURST)) ? BURST_W'(MAX_BURST) : BURST_W'(remaining);
  assign beat = readdatavalid && (state == DATA);
  assign last_beat = beat && (beat_cnt == BURST_W'(1));
  assign read = (state == REQ);
  assign address = addr;
  assign burstcount = read ? bc : '0;
  assign read_done = (state == DONE);
  assign read_valid = beat;
  assign read_data = readdata;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (read_start) state_nx = (read_cnt == '0) ? DONE : REQ;
      REQ: if (!waitrequest) state_nx = DATA;
      DATA: if (last_beat) state_nx = (remaining == CNT_W'(1)) ? DONE : REQ;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      beat_cnt <= '0;
      cur_burst <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && read_start) begin
        addr <= read_addr;
        remaining <= read_cnt;
      end
      if (state == REQ && !waitrequest) begin
        beat_cnt <= bc;
        cur_burst <= bc;
      end
      if (beat) begin
        beat_cnt <= beat_cnt - BURST_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
      // burst length is remembered so the stride is applied once per burst
      if (last_beat) addr <= addr + ADDR_W'(cur_burst) * ADDR_W'(SDRAM_DATA_W / 8);
    end
  end
endmodule

// File: tb/tb_avmm_sdram_reader.sv
// tb_avmm_sdram_reader: scoreboard bench with an Avalon slave model for avmm_sdram_reader.
module tb_avmm_sdram_reader;
  logic clk = 0;
  logic rst_n, read_start, read_valid, read_done, read, waitrequest, readdatavalid;
  logic [31:0] read_addr, read_cnt, address;
  logic [10:0] burstcount;
  logic [127:0] read_data, readdata;
  always #5 clk = ~clk;
  avmm_sdram_reader dut (
    .clk(clk), .rst_n(rst_n), .read_addr(read_addr), .read_cnt(read_cnt),
    .read_start(read_start), .read_valid(read_valid), .read_data(read_data),
    .read_done(read_done), .address(address), .burstcount(burstcount), .read(read),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid)
  );
  typedef struct {logic [31:0] a; logic [10:0] bc;} burst_t;
  logic [127:0] exp_data[$];
  burst_t exp_burst[$];
  int exp_done[$];
  int checks = 0, fails = 0, nbeats = 0, ndone = 0, read_cycles = 0, stall_cycles = 0;
  int beats_left = 0, stall_left = 0;
  bit gappy = 0, junk = 0;
  function automatic logic [127:0] sd(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0001_0001};
  endfunction
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push_data(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) exp_data.push_back(sd(a + 32'(i * 16)));
  endtask
  task automatic push_burst(input logic [31:0] a, input logic [10:0] bc);
    burst_t b;
    b.a = a;
    b.bc = bc;
    exp_burst.push_back(b);
  endtask
  task automatic start(input logic [31:0] a, input logic [31:0] n);
    read_addr = a;
    read_cnt = n;
    read_start = 1;
    @(posedge clk); #1;
    read_start = 0;
    if (n != 0) check("req_latency", read, 1);
    else begin
      check("zero_no_read", read, 0);
      check("zero_done", read_done, 1);
    end
  endtask
  task automatic wait_idle(input int n);
    int i = 0;
    while (exp_done.size() != 0 && i < n) begin
      @(posedge clk);
      i++;
    end
    check("timeout_pending_done", exp_done.size(), 0);
    if (exp_done.size() != 0) begin
      exp_done.delete();
      exp_data.delete();
      exp_burst.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask
  // Avalon slave: returns one beat per cycle (or every other cycle when gappy), data tagged by byte address
  logic acc_s, live;
  logic [31:0] acc_a, cur_a;
  logic [10:0] acc_bc;
  initial begin
    waitrequest = 0; readdatavalid = 0; readdata = '0; live = 0; cur_a = 0;
    forever begin
      @(negedge clk);
      acc_s = read && !waitrequest;
      acc_a = address;
      acc_bc = burstcount;
      @(posedge clk); #1;
      if (live) begin
        beats_left--;
        cur_a += 32'd16;
      end
      if (acc_s === 1'b1) begin
        beats_left += int'(acc_bc);
        cur_a = acc_a;
      end
      live = beats_left > 0 && !(gappy && live);
      readdatavalid = live || junk;
      readdata = live ? sd(cur_a) : {4{32'hDEAD_BEEF}};
      waitrequest = read && stall_left > 0;
      if (waitrequest) stall_left--;
    end
  end
  logic prev_read = 0, prev_wait = 0, prev_valid = 0, prev_start = 0, prev_done = 0;
  logic [31:0] prev_addr = 0;
  logic [10:0] prev_bc = 0;
  initial begin
    burst_t b;
    int t;
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_data.size() == 0) check("spurious_valid", read_valid, 0);
      else if (read_valid) check("beat_data", read_data, exp_data.pop_front());
      if (read_valid) nbeats++;
      if (read) read_cycles++;
      if (read && waitrequest) stall_cycles++;
      if (read && prev_read && prev_wait) begin
        check("stall_address", address, prev_addr);
        check("stall_burstcount", burstcount, prev_bc);
      end
      if (exp_burst.size() == 0) check("spurious_burst", read && !waitrequest, 0);
      else if (read && !waitrequest) begin
        b = exp_burst.pop_front();
        check("burst_address", address, b.a);
        check("burst_count", burstcount, b.bc);
      end
      if (read_done) begin
        ndone++;
        check("done_width", prev_done, 0);
      end
      if (exp_done.size() == 0) check("spurious_done", read_done, 0);
      else if (read_done) begin
        t = exp_done.pop_front();
        if (t == 0) check("done_after_last_beat", {prev_valid, exp_data.size() == 0}, 2'b11);
        else check("done_after_zero_start", prev_start, 1);
      end
      prev_read = read; prev_wait = waitrequest; prev_valid = read_valid;
      prev_start = read_start; prev_done = read_done; prev_addr = address; prev_bc = burstcount;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end
  initial begin
    int b0, d0, s0, r0, i;
    rst_n = 0; read_start = 0; read_addr = 0; read_cnt = 0;
    junk = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_read", read, 0);
    check("rst_done", read_done, 0);
    check("rst_valid", read_valid, 0);
    check("rst_address", address, 0);
    check("rst_burstcount", burstcount, 0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1 junk = 0;
    repeat (2) @(posedge clk);
    #1;
    b0 = nbeats; d0 = ndone;
    push_burst(32'h2000_0000, 64);
    push_burst(32'h2000_0400, 64);
    push_burst(32'h2000_0800, 48);
    push_data(32'h2000_0000, 176);
    exp_done.push_back(0);
    start(32'h2000_0000, 176);
    repeat (40) @(posedge clk);
    #1;
    read_addr = 32'h0000_1234; read_cnt = 5; read_start = 1;
    @(posedge clk); #1;
    read_start = 0;
    wait_idle(800);
    check("beats_3burst", nbeats - b0, 176);
    check("done_3burst", ndone - d0, 1);
    b0 = nbeats; s0 = stall_cycles;
    stall_left = 5;
    push_burst(32'h0000_0100, 8);
    push_data(32'h0000_0100, 8);
    exp_done.push_back(0);
    start(32'h0000_0100, 8);
    wait_idle(200);
    check("stall_cycles", stall_cycles - s0, 5);
    check("beats_stall", nbeats - b0, 8);
    b0 = nbeats;
    gappy = 1;
    push_burst(32'h3000_0000, 4);
    push_data(32'h3000_0000, 4);
    exp_done.push_back(0);
    start(32'h3000_0000, 4);
    wait_idle(200);
    gappy = 0;
    check("beats_gappy", nbeats - b0, 4);
    r0 = read_cycles; d0 = ndone;
    exp_done.push_back(1);
    start(32'h0000_0040, 0);
    wait_idle(50);
    check("zero_read_cycles", read_cycles - r0, 0);
    check("zero_done_count", ndone - d0, 1);
    b0 = nbeats; d0 = ndone;
    push_burst(32'h5000_0000, 64);
    push_burst(32'h5000_0400, 36);
    push_data(32'h5000_0000, 100);
    exp_done.push_back(0);
    start(32'h5000_0000, 100);
    i = 0;
    while (nbeats - b0 < 10 && i < 200) begin
      @(posedge clk);
      i++;
    end
    #1 rst_n = 0;
    @(posedge clk); #1;
    exp_data.delete();
    exp_burst.delete();
    exp_done.delete();
    @(posedge clk); #1;
    check("midrst_read", read, 0);
    check("midrst_done", read_done, 0);
    check("midrst_valid", read_valid, 0);
    rst_n = 1;
    i = 0;
    while (beats_left > 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_done", ndone - d0, 0);
    b0 = nbeats; d0 = ndone;
    push_burst(32'hFFFF_FC00, 64);
    push_burst(32'h0000_0000, 6);
    push_data(32'hFFFF_FC00, 70);
    exp_done.push_back(0);
    start(32'hFFFF_FC00, 70);
    wait_idle(400);
    check("beats_rerun", nbeats - b0, 70);
    check("done_rerun", ndone - d0, 1);
    check("left_data", exp_data.size(), 0);
    check("left_bursts", exp_burst.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
